// File: rtl/onehot_seq_decoder_if.sv
// Bus bundle for onehot_seq_decoder: index/load/run controls in,
// registered one-hot select, index and step strobe out.
interface onehot_seq_decoder_if #(
    parameter int SEL_W = 3
) ();
    localparam int OUT_W = 2**SEL_W;

    logic [SEL_W-1:0] sel;
    logic             load;
    logic             run_en;
    logic             dir;
    logic [OUT_W-1:0] out;
    logic [SEL_W-1:0] idx;
    logic             step_pulse;

    modport master (
        output sel, load, run_en, dir,
        input  out, idx, step_pulse
    );

    modport slave (
        input  sel, load, run_en, dir,
        output out, idx, step_pulse
    );
endinterface

// File: rtl/onehot_seq_decoder.sv
// Registered SEL_W -> 2**SEL_W one-hot decoder with a prescaled RUN mode
// that rotates the hot bit up or down (running light / channel scan).
// Optional build macro ONEHOT_SEQ_BOUNCE_EN: the hot bit reflects at the
// ends instead of wrapping, with the direction held in an internal flop.
module onehot_seq_decoder #(
    parameter int SEL_W   = 3,
    parameter int CNT_MAX = 24_999_999,
    parameter int CNT_W   = 25
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    onehot_seq_decoder_if.slave   bus
);
    localparam int OUT_W = 2**SEL_W;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic             step_q, step_d;
    logic             tc;
`ifdef ONEHOT_SEQ_BOUNCE_EN
    logic             dir_r, dir_r_d;
    logic             init_q;
`endif

    // FSM state register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state_q <= IDLE;
        else            state_q <= state_d;
    end

    // Next state, prescaler and index/one-hot update; load beats the step
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        step_d  = 1'b0;
`ifdef ONEHOT_SEQ_BOUNCE_EN
        dir_r_d = dir_r;
`endif
        tc = (state_q == RUN) && (cnt_q == CNT_W'(CNT_MAX));

        case (state_q)
            IDLE:    if (bus.run_en)  state_d = RUN;
            RUN:     if (!bus.run_en) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        cnt_d = (state_q == RUN && bus.run_en && !tc) ? cnt_q + CNT_W'(1) : '0;

`ifdef ONEHOT_SEQ_BOUNCE_EN
        // direction is captured on the first clock after reset and on RUN entry
        if (init_q || (state_q == IDLE && bus.run_en)) dir_r_d = bus.dir;
`endif

        if (bus.load) begin
            idx_d = bus.sel;
            cnt_d = '0;
`ifdef ONEHOT_SEQ_BOUNCE_EN
            dir_r_d = bus.dir;
`endif
        end else if (tc) begin
            step_d = 1'b1;
`ifdef ONEHOT_SEQ_BOUNCE_EN
            if (!dir_r) begin
                if (idx_q == '1) begin
                    idx_d   = idx_q - SEL_W'(1);
                    dir_r_d = 1'b1;
                end else begin
                    idx_d = idx_q + SEL_W'(1);
                end
            end else begin
                if (idx_q == '0) begin
                    idx_d   = SEL_W'(1);
                    dir_r_d = 1'b0;
                end else begin
                    idx_d = idx_q - SEL_W'(1);
                end
            end
`else
            idx_d = bus.dir ? idx_q - SEL_W'(1) : idx_q + SEL_W'(1);
`endif
        end

        out_d = OUT_W'(1) << idx_d;
    end

    // Datapath registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            out_q  <= OUT_W'(1);
            step_q <= 1'b0;
`ifdef ONEHOT_SEQ_BOUNCE_EN
            dir_r  <= 1'b0;
            init_q <= 1'b1;
`endif
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            out_q  <= out_d;
            step_q <= step_d;
`ifdef ONEHOT_SEQ_BOUNCE_EN
            dir_r  <= dir_r_d;
            init_q <= 1'b0;
`endif
        end
    end

    assign bus.out        = out_q;
    assign bus.idx        = idx_q;
    assign bus.step_pulse = step_q;

    a_onehot: assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
        ($onehot(out_q) && out_q == (OUT_W'(1) << idx_q)));
endmodule
